pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush/forwarding controller for the 5-stage RV32 pipeline. Drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from hazard information tapped out of each stage, and sequences multi-cycle data-memory accesses with a req/ready handshake. Also generates the EX-stage operand forwarding selects and a saturating stall-cycle counter.

## Interface
- `MEM_TIMEOUT`, default 15: maximum number of MEM_WAIT cycles before a fatal error (1..255).
- `CNT_W`, default 16: width of the stall-cycle counter.
- `clk` in 1: pipeline clock.
- `reset` in 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1 each: the ID instruction actually reads that source.
- `ex_rs1`, `ex_rs2` in 5 each: source registers of the instruction in EX.
- `ex_rd` in 5, `ex_reg_write` in 1, `ex_mem_read` in 1: EX destination and its kind.
- `mem_rd` in 5, `mem_reg_write` in 1: MEM destination.
- `wb_rd` in 5, `wb_reg_write` in 1: WB destination.
- `ex_branch_taken` in 1: EX resolved a taken branch or jump.
- `mem_access` in 1: the instruction in MEM is a load or store.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `dmem_req` out 1: data-memory request.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1 each: register load enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` out 1 each: load a bubble (all zeros).
- `fwd_a`, `fwd_b` out 2 each: EX operand select. 0 = register file, 1 = WB value, 2 = MEM value.
- `mem_err` out 1: sticky memory-timeout error.
- `stall_cycles` out `CNT_W`: saturating count of cycles with `pc_en` = 0 outside reset.

## Operation
- States: RUN, MEM_WAIT, ERR. State is registered; all outputs are combinational from the state plus the current inputs.
- Hazard priority within RUN/MEM_WAIT: memory stall > branch flush > load-use/RAW stall.
- **Memory stall.** Applies when `mem_access` = 1 and `dmem_ready` = 0.
  - `pc_en`, `if_id_en`, `id_ex_en` and `ex_mem_en` are 0.
  - `mem_wb_flush` = 1, so a bubble enters WB.
  - RUN moves to MEM_WAIT. The machine stays in MEM_WAIT while `dmem_ready` = 0.
  - On the first cycle with `dmem_ready` = 1, all enables are 1 and the next state is RUN.
- **Memory handshake.** `dmem_req` = `mem_access` in RUN and MEM_WAIT; 0 in ERR. The request is held until ready.
- **Timeout.** A wait counter resets on entry to MEM_WAIT and increments each MEM_WAIT cycle. When the count reaches `MEM_TIMEOUT` with ready still low, the next state is ERR.
- **ERR.** All enables are 0, all flushes are 0, `mem_err` = 1. ERR is left only by reset.
- **Branch.** When `ex_branch_taken` = 1 and there is no memory stall:
  - `pc_en` = 1 (the PC loads the target).
  - `if_id_flush` = 1 and `id_ex_flush` = 1.
  - Any simultaneous load-use stall is suppressed, because the ID instruction is discarded.
  - A branch held in EX during a memory stall is acted on in the release cycle.
- **Load-use stall (with forwarding).** Condition: `ex_mem_read` = 1, `ex_rd` ≠ 0, and `ex_rd` matches a used ID source. Response for one cycle: `pc_en` = 0, `if_id_en` = 0, `id_ex_flush` = 1.
- **Forwarding.** For each EX source (`fwd_a` for `ex_rs1`, `fwd_b` for `ex_rs2`):
  - 2 if `mem_reg_write` = 1, `mem_rd` ≠ 0 and `mem_rd` matches the source.
  - Else 1 if the same holds for the WB destination.
  - Else 0.
  - x0 is never forwarded.
- **Stall counter.** `stall_cycles` increments when `pc_en` = 0 in RUN or MEM_WAIT. It saturates at all-ones and is never cleared except by reset.

## Timing
- While `reset` = 0 (sampled at an edge):
  - Next state is RUN; the wait counter, `stall_cycles` and `mem_err` become 0.
  - Combinationally during reset: all enables are 0 and all three flushes are 1, so the pipeline registers clear.
- Stall and flush responses have zero-cycle latency: they are asserted in the same cycle as the triggering inputs.
- Reset asserted during MEM_WAIT or ERR returns to RUN on the next edge. `dmem_req` is dropped during reset.
- With `MEM_TIMEOUT` = N, ERR is entered on the edge after the N-th consecutive not-ready MEM_WAIT cycle.
- `dmem_ready` = 1 on that same cycle wins: the access completes and the next state is RUN.

## Configuration
- `PIPE_FORWARDING_EN` defined:
  - Forwarding operates as above.
  - Only load-use hazards stall, for one cycle.
- `PIPE_FORWARDING_EN` undefined:
  - `fwd_a` and `fwd_b` are tied to 0.
  - A RAW stall (same response as load-use) is raised whenever a used ID source ≠ 0 matches `ex_rd` with `ex_reg_write` = 1, or `mem_rd` with `mem_reg_write` = 1.
  - WB hazards are covered by the register file's write-before-read behaviour.

## Structure
- The shared package `pipe_pkg` holds:
  - the state enum (RUN, MEM_WAIT, ERR);
  - the forwarding-select constants FWD_RF = 0, FWD_WB = 1, FWD_MEM = 2.
- The combinational forwarding/hazard comparators form one sub-module, `hazard_detect`. The FSM, counters and priority muxing stay in `pipeline_ctrl`.

## Test plan
- **Reset.** Hold `reset` = 0 for 2 cycles. Expect all enables 0, all flushes 1, `stall_cycles` = 0, `mem_err` = 0. After release, expect all enables 1.
- **Load-use.** `ex_mem_read` = 1, `ex_rd` = 5, `id_rs1` = 5, `id_use_rs1` = 1. Expect exactly one cycle of `pc_en` = 0 and `id_ex_flush` = 1, and `stall_cycles` = 1. Repeat with `ex_rd` = 0: expect no stall.
- **Branch.** `ex_branch_taken` = 1 together with a load-use condition. Expect `pc_en` = 1, `if_id_flush` = 1, `id_ex_flush` = 1, and no stall.
- **Memory wait.** `mem_access` = 1 with `dmem_ready` low for 3 cycles, then high. Expect 3 frozen cycles with a bubble into WB each cycle, release on the 4th cycle, and `stall_cycles` = 3.
- **Timeout.** `MEM_TIMEOUT` = 4 with `dmem_ready` held at 0. Expect ERR after 4 wait cycles: `mem_err` = 1, `dmem_req` = 0, all enables 0. Then `reset` = 0 for one cycle returns to RUN.
- **Forwarding.** `mem_rd` = 7 and `wb_rd` = 7, both with write enables set, and `ex_rs1` = 7. Expect `fwd_a` = 2. With only the WB write enable set, expect `fwd_a` = 1. Rebuild without `PIPE_FORWARDING_EN`: expect `fwd_a` = 0 and a RAW stall for an ID match on `ex_rd`.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline controller: FSM states and
// EX-stage operand forwarding selects.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  // Newest producer wins; x0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] mem_rd,
                                         input logic       mem_we,
                                         input logic [4:0] wb_rd,
                                         input logic       wb_we);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational register comparators: EX forwarding selects and the ID-stage
// data-hazard stall request. Behaviour depends on PIPE_FORWARDING_EN.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       hazard_stall
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit  = (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    mem_hit = (mem_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == mem_rd)) || (id_use_rs2 && (id_rs2 == mem_rd)));
  end

`ifdef PIPE_FORWARDING_EN
  logic unused_fwd;
  assign unused_fwd = ex_reg_write ^ mem_hit;

  always_comb begin
    fwd_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    fwd_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    // Only a load result is too late to forward into the dependent EX.
    hazard_stall = ex_mem_read && ex_hit;
  end
`else
  logic unused_nofwd;
  assign unused_nofwd = ^{ex_rs1, ex_rs2, wb_rd, wb_reg_write, ex_mem_read};

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    // WB producers are covered by write-before-read in the register file.
    hazard_stall = (ex_reg_write && ex_hit) || (mem_reg_write && mem_hit);
  end
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline with data-memory
// wait sequencing and timeout. Optional feature macro: PIPE_FORWARDING_EN.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e           state_q;
  logic [7:0]       wait_q;
  logic [CNT_W-1:0] stall_q;
  logic             hazard_stall;
  logic             mem_stall;

  hazard_detect u_hazard_detect (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .hazard_stall  (hazard_stall)
  );

  assign mem_stall    = (state_q != ERR) && mem_access && !dmem_ready;
  assign stall_cycles = stall_q;

  // Priority: reset > error > memory stall > branch flush > data hazard.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    dmem_req     = mem_access;
    mem_err      = 1'b0;
    if (!reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      dmem_req     = 1'b0;
    end else if (state_q == ERR) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      dmem_req  = 1'b0;
      mem_err   = 1'b1;
    end else if (mem_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hazard_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      if (!pc_en && (state_q != ERR) && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      unique case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_q <= MEM_WAIT;
            wait_q  <= '0;
          end
        end
        MEM_WAIT: begin
          if (!mem_stall) begin
            state_q <= RUN;
          end else if (wait_q == WaitLast) begin
            state_q <= ERR;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ERR:     state_q <= ERR;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus random traffic
// against a cycle-level reference model.
module tb_pipeline_ctrl;

  localparam int TO = 4;
  localparam int CW = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
  logic ex_branch_taken, mem_access, dmem_ready;
  logic dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cycles;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]    en;   // pc, if_id, id_ex, ex_mem, mem_wb
    logic [2:0]    fl;   // if_id, id_ex, mem_wb
    logic [3:0]    fwd;  // fwd_a, fwd_b
    logic          req;
    logic          err;
    logic [CW-1:0] sc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state: waiting on memory, completed wait cycles, error, stall count.
  bit m_wait = 0;
  bit m_err = 0;
  int m_waited = 0;
  int m_count = 0;

  function automatic bit id_uses(input logic [4:0] r);
    return (r != 5'd0) && ((id_use_rs1 && id_rs1 == r) || (id_use_rs2 && id_rs2 == r));
  endfunction

  function automatic logic [1:0] src_fwd(input logic [4:0] s);
`ifdef PIPE_FORWARDING_EN
    if (s != 0 && mem_reg_write && mem_rd == s) return 2'd2;
    if (s != 0 && wb_reg_write && wb_rd == s) return 2'd1;
`endif
    return 2'd0 + 2'(s & 5'd0);
  endfunction

  function automatic bit data_hazard();
`ifdef PIPE_FORWARDING_EN
    return ex_mem_read && id_uses(ex_rd);
`else
    return (ex_reg_write && id_uses(ex_rd)) || (mem_reg_write && id_uses(mem_rd));
`endif
  endfunction

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write} = '0;
    {ex_branch_taken, mem_access} = '0;
    dmem_ready = 1'b1;
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, then advance the model.
  task automatic cycle();
    exp_t e;
    bit mstall;
    mstall = mem_access && !dmem_ready;
    e.sc  = m_count[CW-1:0];
    e.fwd = {src_fwd(ex_rs1), src_fwd(ex_rs2)};
    e.err = 1'b0;
    e.req = mem_access;
    if (!reset) begin
      e.en = 5'b00000; e.fl = 3'b111; e.req = 1'b0;
    end else if (m_err) begin
      e.en = 5'b00000; e.fl = 3'b000; e.req = 1'b0; e.err = 1'b1;
    end else if (mstall) begin
      e.en = 5'b00001; e.fl = 3'b001;
    end else if (ex_branch_taken) begin
      e.en = 5'b11111; e.fl = 3'b110;
    end else if (data_hazard()) begin
      e.en = 5'b00111; e.fl = 3'b010;
    end else begin
      e.en = 5'b11111; e.fl = 3'b000;
    end
    q.push_back(e);
    if (!reset) begin
      m_wait = 0; m_err = 0; m_waited = 0; m_count = 0;
    end else if (!m_err) begin
      if (!e.en[4] && m_count < CMAX) m_count++;
      if (mstall) begin
        if (m_wait) begin
          m_waited++;
          if (m_waited >= TO) m_err = 1;
        end else begin
          m_wait = 1;
          m_waited = 0;
        end
      end else begin
        m_wait = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("enables", {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, e.en});
      chk("flushes", {29'd0, if_id_flush, id_ex_flush, mem_wb_flush}, {29'd0, e.fl});
      chk("fwd", {28'd0, fwd_a, fwd_b}, {28'd0, e.fwd});
      chk("req_err", {30'd0, dmem_req, mem_err}, {30'd0, e.req, e.err});
      chk("stall_cycles", 32'(stall_cycles), 32'(e.sc));
    end
  end

  initial begin
    clear_inputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    // Reset held a second cycle, then released.
    cycle();
    reset = 1'b1;
    cycle();
    // Load-use on rs1, then with rd = x0.
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    cycle();
    ex_mem_read = 0; ex_reg_write = 0;
    cycle();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 0; id_rs1 = 0;
    cycle();
    // Branch overriding a load-use.
    ex_rd = 5; id_rs1 = 5; ex_branch_taken = 1;
    cycle();
    clear_inputs();
    reset = 1'b0; cycle(); reset = 1'b1;
    // Three-cycle memory wait with a branch held in EX, released on the fourth.
    mem_access = 1; dmem_ready = 0; ex_branch_taken = 1;
    repeat (3) cycle();
    dmem_ready = 1;
    cycle();
    clear_inputs();
    cycle();
    // Timeout into ERR, then a one-cycle reset.
    mem_access = 1; dmem_ready = 0;
    repeat (8) cycle();
    reset = 1'b0; cycle(); reset = 1'b1;
    // Ready on the last allowed wait cycle completes the access.
    repeat (TO) cycle();
    dmem_ready = 1; cycle();
    clear_inputs();
    cycle();
    // Forwarding priority and the no-forwarding RAW stall.
    mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1; ex_rs1 = 7; ex_rs2 = 7;
    cycle();
    mem_reg_write = 0;
    cycle();
    clear_inputs();
    ex_reg_write = 1; ex_rd = 3; id_rs2 = 3; id_use_rs2 = 1;
    cycle();
    clear_inputs();
    mem_reg_write = 1; mem_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
    cycle();
    // Saturate the stall counter.
    clear_inputs();
    mem_access = 1; dmem_ready = 0;
    repeat (2) cycle();
    dmem_ready = 1; cycle();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
    repeat (CMAX + 5) cycle();
    clear_inputs();
    reset = 1'b0; cycle(); reset = 1'b1;
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 149) != 0);
      id_rs1          = 5'($urandom_range(0, 7));
      id_rs2          = 5'($urandom_range(0, 7));
      ex_rs1          = 5'($urandom_range(0, 7));
      ex_rs2          = 5'($urandom_range(0, 7));
      ex_rd           = 5'($urandom_range(0, 7));
      mem_rd          = 5'($urandom_range(0, 7));
      wb_rd           = 5'($urandom_range(0, 7));
      id_use_rs1      = 1'($urandom);
      id_use_rs2      = 1'($urandom);
      ex_reg_write    = 1'($urandom);
      ex_mem_read     = 1'($urandom);
      mem_reg_write   = 1'($urandom);
      wb_reg_write    = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_access      = ($urandom_range(0, 2) == 0) || (i % 400 > 380);
      dmem_ready      = (i % 400 > 380) ? 1'b0 : ($urandom_range(0, 2) != 0);
      cycle();
    end
    clear_inputs();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
